// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the multi-port register file
package regfile_pkg;
    typedef enum logic [1:0] {RF_CLEAR, RF_IDLE} rf_state_e;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one asynchronous read port with zero-register and busy gating
// REGFILE_BYPASS_EN adds write-first forwarding from the write port
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
    input  logic              busy_i,
    input  logic [ADDR_W-1:0] ra_i,
`ifdef REGFILE_BYPASS_EN
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
`endif
    output logic [DATA_W-1:0] rd_o
);
    logic [DATA_W-1:0] raw;
`ifdef REGFILE_BYPASS_EN
    assign raw = (we_i && wa_i == ra_i) ? wd_i : mem_i[ra_i];
`else
    assign raw = mem_i[ra_i];
`endif
    assign rd_o = (busy_i || (ZERO_REG != 0 && ra_i == '0)) ? '0 : raw;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with sequenced clear engine
// REGFILE_BYPASS_EN selects write-first forwarding on the read ports
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     clear_req,
    output logic                     init_busy
);
    localparam int DEPTH = 2**ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic              init_busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_acc;
    logic              clr_last;

    assign wr_acc   = we && state_q == RF_IDLE && !clear_req && !(ZERO_REG != 0 && wa == '0);
    assign clr_last = clr_cnt_q == (ADDR_W+1)'(DEPTH-1);
    assign init_busy = init_busy_q;

    always_comb begin
        state_d   = state_q == RF_CLEAR ? (clr_last ? RF_IDLE : RF_CLEAR)
                                        : (clear_req ? RF_CLEAR : RF_IDLE);
        clr_cnt_d = state_q == RF_CLEAR ? clr_cnt_q + (ADDR_W+1)'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RF_CLEAR;
            clr_cnt_q   <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_busy_q <= state_d == RF_CLEAR;
        end
    end

    // The array itself is never reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR)
            mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
        else if (wr_acc)
            mem_q[wa] <= wd;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .mem_i (mem_q),
            .busy_i(init_busy_q),
            .ra_i  (ra[k*ADDR_W +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
            .we_i  (wr_acc),
            .wa_i  (wa),
            .wd_i  (wd),
`endif
            .rd_o  (rd[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench running a zero-register and a plain instance side by side
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

    logic clk = 1'b0, reset = 1'b1, we = 1'b0, clear_req = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic [NR*AW-1:0] ra = '0;
    logic [NR*DW-1:0] rd_a, rd_b;
    logic busy_a, busy_b;

    typedef struct packed {
        logic [NR*DW-1:0] rda;
        logic [NR*DW-1:0] rdb;
        logic             busy;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    int left = 0, cyc = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
        .clear_req(clear_req), .init_busy(busy_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
        .clear_req(clear_req), .init_busy(busy_b)
    );

    function automatic logic [DW-1:0] model_rd(input bit z, input logic [AW-1:0] a);
        if (left != 0 || (z && a == '0)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && !clear_req && !(z && wa == '0) && wa == a) return wd;
`endif
        return z ? mem_a[a] : mem_b[a];
    endfunction

    // Abstract clear: contents vanish at once, since reads are forced to 0 while busy anyway.
    task automatic start_clear();
        left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic c, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        exp_t x;
        reset = r; we = w; wa = a; wd = d; clear_req = c; ra = {r1, r0};
        x.rda  = {model_rd(1'b1, r1), model_rd(1'b1, r0)};
        x.rdb  = {model_rd(1'b0, r1), model_rd(1'b0, r0)};
        x.busy = left != 0;
        x.cyc  = cyc;
        sb.push_back(x);
        @(posedge clk);
        if (r || (left == 0 && c)) start_clear();
        else if (left != 0) left--;
        else if (w) begin
            if (a != '0) mem_a[a] = d;
            mem_b[a] = d;
        end
        #1;
        cyc++;
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        step(1'b0, 1'b0, '0, '0, 1'b0, r0, r1);
    endtask

    task automatic chk(input string n, input int c, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", n, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("busy_zr", e.cyc, {{(NR*DW-1){1'b0}}, busy_a}, {{(NR*DW-1){1'b0}}, e.busy});
            chk("busy_nz", e.cyc, {{(NR*DW-1){1'b0}}, busy_b}, {{(NR*DW-1){1'b0}}, e.busy});
            chk("rd_zr", e.cyc, rd_a, e.rda);
            chk("rd_nz", e.cyc, rd_b, e.rdb);
        end
    end

    logic [AW-1:0] ra_r, rb_r, wa_r;
    logic r_r, c_r, w_r;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        start_clear();
        reset = 1'b0;
        repeat (DEPTH) step(1'b0, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0, AW'(5), AW'(5));
        idle(AW'(5), AW'(5));
        step(1'b0, 1'b1, AW'(7), 32'h12345678, 1'b0, AW'(7), AW'(7));
        idle(AW'(7), AW'(7));
        step(1'b0, 1'b1, AW'(0), 32'hFFFFFFFF, 1'b0, AW'(0), AW'(0));
        idle(AW'(0), AW'(0));
        step(1'b0, 1'b1, AW'(3), 32'hA5A5A5A5, 1'b0, AW'(3), AW'(3));
        idle(AW'(3), AW'(3));
        for (int i = 1; i < DEPTH; i++)
            step(1'b0, 1'b1, AW'(i), $urandom() | 32'h1, 1'b0, AW'(i), AW'(i - 1));
        step(1'b0, 1'b1, AW'(9), 32'h0BADF00D, 1'b1, AW'(9), AW'(1));
        repeat (DEPTH) idle(AW'(9), AW'(1));
        for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));
        for (int i = 1; i < DEPTH; i++)
            step(1'b0, 1'b1, AW'(i), $urandom() | 32'h1, 1'b0, AW'(i), AW'(0));
        step(1'b0, 1'b0, '0, '0, 1'b1, AW'(4), AW'(8));
        repeat (9) idle(AW'(4), AW'(8));
        step(1'b1, 1'b0, '0, '0, 1'b0, AW'(4), AW'(8));
        repeat (DEPTH) idle(AW'(4), AW'(8));
        for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));
        for (int i = 0; i < 1500; i++) begin
            r_r  = $urandom_range(0, 199) == 0;
            c_r  = $urandom_range(0, 59) == 0;
            w_r  = $urandom_range(0, 3) != 0;
            wa_r = AW'($urandom_range(0, DEPTH - 1));
            ra_r = $urandom_range(0, 3) == 0 ? wa_r : AW'($urandom_range(0, DEPTH - 1));
            rb_r = $urandom_range(0, 7) == 0 ? AW'(0) : AW'($urandom_range(0, DEPTH - 1));
            step(r_r, w_r, wa_r, $urandom(), c_r, ra_r, rb_r);
        end
        idle(AW'(1), AW'(2));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the single-cycle MIPS datapath and its successors. It replaces the fixed 32x32 two-address file with configurable data width, depth and read-port count. It adds a hardwired-zero register 0, a synchronous reset, and a sequenced clear engine that zeroes the array one entry per cycle. It sits between instruction decode (read addresses) and the writeback mux (write port).

## Interface
Parameters:
- `DATA_W`, 32, data width in bits.
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`.
- `NUM_RD`, 2, number of independent read ports (1..4).
- `ZERO_REG`, 1, when 1, entry 0 reads as 0 and ignores writes.

Ports:
- Clocking: one clock; reset is synchronous and active-high. Ports are `clk` and `reset`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; starts a clear sequence.
- `we`  in  1  write enable (RegWrite).
- `wa`  in  ADDR_W  write address (A3).
- `wd`  in  DATA_W  write data (WD3).
- `ra`  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- `rd`  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
- `clear_req`  in  1  single-cycle request to re-zero the whole array.
- `init_busy`  out  1  registered; high while a clear sequence runs.

## Operation
- FSM states: CLEAR and IDLE. A 2-bit state register is sufficient.
  - `reset` puts the FSM in CLEAR with `clr_cnt`=0. This applies in every state, including mid-clear, where it restarts from 0.
  - In CLEAR, each cycle writes 0 to entry `clr_cnt`, then increments `clr_cnt`. When `clr_cnt`=DEPTH-1 is written, the FSM goes to IDLE.
  - In IDLE, `clear_req`=1 sends the FSM to CLEAR with `clr_cnt`=0. In CLEAR, `clear_req` is ignored.
- Write acceptance: a write is accepted when `we` && state==IDLE && !`clear_req` && !(ZERO_REG && `wa`==0).
  - Writes during CLEAR are dropped, not queued.
  - If `clear_req` and `we` occur in the same cycle, the clear wins and the write is dropped.
- Reads: combinational (asynchronous) and index the array per port.
  - During CLEAR, every `rd` port returns 0, regardless of the array contents.
  - When ZERO_REG=1, `ra`==0 returns 0.
  - Multiple ports may read the same address simultaneously.
- `clr_cnt` is ADDR_W+1 bits wide, so the terminal compare does not wrap. Array entries are DATA_W bits. There is no arithmetic on the data.

## Timing
- Reset values: state=CLEAR, `clr_cnt`=0, `init_busy`=1. All `rd` outputs are 0 from the first cycle after the reset edge.
- Clear latency: after `reset` deasserts, `init_busy` stays high for exactly DEPTH rising edges (32 with the defaults), then goes low. The first write can be accepted on the edge after `init_busy` falls.
- `clear_req` sampled at edge N causes `init_busy`=1 after edge N. `init_busy` falls after edge N+DEPTH.
- Write latency: a write issued at edge N becomes visible on `rd` after edge N (the same-cycle read returns the old value unless the bypass is compiled in).
- Reads have zero-cycle latency from `ra` to `rd`.

## Configuration
- Macro `REGFILE_BYPASS_EN`:
  - Defined: write-first forwarding. If a write is accepted this cycle and `wa`==`ra[k]`, port k returns `wd` combinationally. The zero-register rule still overrides this.
  - Undefined: read-before-write. Port k returns the stored value until the edge.

## Structure
- Package `regfile_pkg`:
  - State enum `rf_state_e` {RF_CLEAR, RF_IDLE}.
  - Default constants `RF_DATA_W`=32 and `RF_ADDR_W`=5.
- Sub-module `regfile_rd_port` contains one read mux, the zero gating, the busy gating and the optional bypass. It is instantiated NUM_RD times in a generate loop.
- The top module holds the array, the FSM, `clr_cnt` and the write-acceptance logic.

## Test plan
- **Reset and clear duration:** pulse `reset` 1 cycle -> `init_busy`=1 for exactly 32 cycles. Throughout, `rd`=0 for `ra`=5. During busy, `we`=1 with `wa`=5 and `wd`=0xDEADBEEF -> reading entry 5 after busy returns 0.
- **Basic write/read:** write 0x12345678 to entry 7 -> the next cycle, port 0 with `ra`=7 reads 0x12345678. Port 1 with `ra`=7 reads the same value in the same cycle.
- **Zero register:** write 0xFFFFFFFF to entry 0 -> `ra`=0 reads 0 on all ports. Repeat with ZERO_REG=0 -> reads 0xFFFFFFFF.
- **Bypass:**
  - With `REGFILE_BYPASS_EN`: `we`=1, `wa`=`ra`=3, `wd`=0xA5A5A5A5 -> `rd`=0xA5A5A5A5 in the same cycle.
  - Without the macro: `rd` shows the old value 0 in that cycle and 0xA5A5A5A5 after the edge.
- **Clear collision:** fill entries 1..31 with nonzero data, then assert `clear_req` with `we`=1, `wa`=9 -> write dropped, `init_busy` high for 32 cycles, then all entries read 0.
- **Reset mid-clear:** assert `reset` on the 10th cycle of a clear -> `init_busy` stays high for 32 further cycles, and entries 0..31 all read 0 afterwards.
